fullxor_sched: RTL and testbench
================================

// Module: fullxor_sched
// PURPOSE
// Round-robin scheduler sharing one 3-share FullXOR recombination unit between NREQ requesters.
// Collects fresh randomness from an external RNG word stream; each operation gets an unused RANDNUM-word set.
// Issues one masked operand per cycle (back-to-back), tags it, and returns the unmasked result with its requester ID.
// Back-pressure on the response port stalls the FullXOR unit through its ena input.
// PARAMETERS
// K_WIDTH   32  bit width of one share / result
// N_SHARES  3   shares per operand (fixed 3 for this unit)
// RANDNUM   2   random K_WIDTH words consumed per operation (matches FullXOR for N_SHARES=3)
// NREQ      4   number of requesters, 2..8
// RSETS     2   rnd buffer depth in complete RANDNUM-word sets, 1..4
// PORTS
// clk       in   1                  clock, all logic on rising edge
// rst       in   1                  synchronous reset, active-high
// req_vld   in   NREQ               requester i has an operand
// req_x     in   NREQ*K*N_SHARES    operand of requester i at [i*K*N_SHARES +: K*N_SHARES]
// req_rdy   out  NREQ               one-hot grant; transfer when req_vld[i]&req_rdy[i]
// rng_vld   in   1                  RNG word valid
// rng_data  in   K_WIDTH            RNG word
// rng_rdy   out  1                  high when rnd buffer can accept a word
// rsp_vld   out  1                  result valid (= fx_ovld)
// rsp_z     out  K_WIDTH            unmasked result (= fx_z)
// rsp_id    out  $clog2(NREQ)       requester index of the result
// rsp_rdy   in   1                  consumer accepts result
// fx_rst_n  out  1                  FullXOR reset, = ~rst
// fx_dvld   out  1                  FullXOR input valid
// fx_ena    out  1                  FullXOR enable
// fx_rnd    out  K_WIDTH*RANDNUM    randomness for issued op
// fx_x      out  K_WIDTH*N_SHARES   operand for issued op
// fx_z      in   K_WIDTH            FullXOR result
// fx_ovld   in   1                  FullXOR output valid
// busy      out  1                  op in flight or any req_vld pending
// op_cnt    out  16                 issued-op count, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: req_rdy=0, rng_rdy=0 during rst, fx_dvld=0, rsp_id=0, op_cnt=0, rr pointer=NREQ-1, rnd buffer empty,
//   word counter=0, FSM=IDLE. fx_ena=1 and fx_rst_n=0 while rst; FullXOR therefore clears ovld -> rsp_vld=0.
// - stall = rsp_vld & ~rsp_rdy; fx_ena = ~stall (combinational).
// - RNG collector: rng_rdy = ~rst & (sets_full < RSETS). Word accepted on rng_vld&rng_rdy into slot word_cnt;
//   on word RANDNUM-1 the set commits (sets_full+1), word_cnt->0. Partial sets are never issued.
// - FSM IDLE: no grant. -> ISSUE when sets_full>0 & |req_vld & ~stall.
//   ISSUE: grant = first req_vld index strictly after rr pointer (wrapping); req_rdy one-hot, combinational;
//   fx_x=req_x[grant], fx_rnd=oldest set, fx_dvld=1; that set popped, rr pointer=grant, op_cnt+1.
//   Stays ISSUE while conditions hold (1 op/cycle); -> STALL if stall; -> IDLE if no req or no set.
//   STALL: req_rdy=0, fx_dvld=0, no set popped; -> ISSUE/IDLE when rsp_rdy rises, per the same conditions.
// - Latency: issue in cycle t -> rsp_vld in t+1 (FullXOR register); held stable while stall.
// - rsp_id register loads grant index when fx_dvld & fx_ena; tracks FullXOR data register exactly.
// - Simultaneous: set commit and pop in same cycle -> sets_full unchanged; commit into last free set and pop in
//   same cycle legal. With sets_full=0, a set completing in cycle t is issuable from t+1 only.
// - Randomness freshness: each committed set popped exactly once; fx_dvld=0 never pops.
// - Reset mid-operation: in-flight op and buffered rnd discarded; no rsp_vld after rst until a new issue.
// STRUCTURE
// - Package fullxor_pkg: RANDNUM function of N_SHARES, ID width, FSM enum {IDLE, ISSUE, STALL}.
// - One sub-module: fullxor_rnd_fifo (RSETS x K_WIDTH*RANDNUM, word assembler, push/pop, full/empty).
// - Round-robin arbiter and tag register in this module; FullXOR instantiated outside, wired via fx_* ports.
// TESTING
// - Reset: rst 3 cycles with req_vld=4'hF -> req_rdy=0, rsp_vld=0, op_cnt=0, rng_rdy=0, then rng_rdy=1.
// - Single op: 2 RNG words 0xA5A5A5A5,0x0F0F0F0F; req1 shares 0x11,0x22,0x44 -> rsp_z=0x77, rsp_id=1 one cycle after grant.
// - Fairness: 4 sets loaded, req_vld=4'hF -> grants 0,1,2,3 on consecutive cycles, rsp_id 0,1,2,3.
// - Rnd starvation: 1 word only, req0 valid -> no grant; 2nd word -> grant next cycle; fx_rnd equals the two words.
// - Back-pressure: rsp_rdy=0 3 cycles during stream -> rsp_z/rsp_id stable, fx_ena=0, no grant, op_cnt frozen.
// - Mid-op reset: rst at issue cycle with 2 sets buffered -> no rsp_vld after, sets_full=0, next op needs 2 new words.

Source files
------------

// File: rtl/fullxor_pkg.sv
// Shared types and sizing helpers for the FullXOR scheduler and its randomness buffer.
package fullxor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_e;

    // Fresh random words one 3-share FullXOR operation consumes.
    function automatic int randnum_f(input int n_shares);
        return n_shares - 1;
    endfunction

    function automatic int id_width_f(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fullxor_rnd_fifo.sv
// Assembles RNG words into RANDNUM-word sets and queues up to RSETS complete sets.
// Word accepted 1/cycle while a set slot is free; a set committed in cycle t is poppable from t+1.
module fullxor_rnd_fifo #(
    parameter int K_WIDTH = 32,
    parameter int RANDNUM = 2,
    parameter int RSETS   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       word_vld_i,
    input  logic [K_WIDTH-1:0]         word_dat_i,
    output logic                       word_rdy_o,
    input  logic                       pop_i,
    output logic [K_WIDTH*RANDNUM-1:0] set_dat_o,
    output logic                       empty_o
);

    localparam int PW = (RSETS > 1) ? $clog2(RSETS) : 1;
    localparam int CW = $clog2(RSETS + 1);
    localparam int WW = (RANDNUM > 1) ? $clog2(RANDNUM) : 1;

    logic [K_WIDTH*RANDNUM-1:0] mem_q [RSETS];
    logic [K_WIDTH*RANDNUM-1:0] asm_q, asm_d;
    logic [WW-1:0]              word_cnt_q, word_cnt_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       full;
    logic                       word_acc;
    logic                       commit;
    logic                       pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSETS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count_q == CW'(RSETS));
    assign empty_o    = (count_q == '0);
    assign word_rdy_o = ~rst & ~full;
    assign word_acc   = word_vld_i & word_rdy_o;
    assign pop_ok     = pop_i & ~empty_o;
    assign set_dat_o  = mem_q[rd_ptr_q];

    // Word i of a set lands at bits [i*K_WIDTH +: K_WIDTH].
    always_comb begin
        asm_d      = asm_q;
        word_cnt_d = word_cnt_q;
        commit     = 1'b0;
        if (word_acc) begin
            asm_d[int'(word_cnt_q)*K_WIDTH +: K_WIDTH] = word_dat_i;
            if (word_cnt_q == WW'(RANDNUM - 1)) begin
                commit     = 1'b1;
                word_cnt_d = '0;
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = commit ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({commit, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q      <= '0;
            word_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            asm_q      <= asm_d;
            word_cnt_q <= word_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[wr_ptr_q] <= asm_d;
        end
    end

endmodule

// File: rtl/fullxor_sched.sv
// Round-robin scheduler feeding one external FullXOR unit; one op/cycle, result 1 cycle after issue.
// A stalled response (rsp_vld & ~rsp_rdy) drops fx_ena, withholds grants and pops no randomness.
module fullxor_sched
    import fullxor_pkg::*;
#(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 3,
    parameter int RANDNUM  = randnum_f(N_SHARES),
    parameter int NREQ     = 4,
    parameter int RSETS    = 2,
    localparam int IDW     = id_width_f(NREQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_vld,
    input  logic [NREQ*K_WIDTH*N_SHARES-1:0] req_x,
    output logic [NREQ-1:0]               req_rdy,
    input  logic                          rng_vld,
    input  logic [K_WIDTH-1:0]            rng_data,
    output logic                          rng_rdy,
    output logic                          rsp_vld,
    output logic [K_WIDTH-1:0]            rsp_z,
    output logic [IDW-1:0]                rsp_id,
    input  logic                          rsp_rdy,
    output logic                          fx_rst_n,
    output logic                          fx_dvld,
    output logic                          fx_ena,
    output logic [K_WIDTH*RANDNUM-1:0]    fx_rnd,
    output logic [K_WIDTH*N_SHARES-1:0]   fx_x,
    input  logic [K_WIDTH-1:0]            fx_z,
    input  logic                          fx_ovld,
    output logic                          busy,
    output logic [15:0]                   op_cnt
);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]    op_cnt_q, op_cnt_d;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    int             arb_idx;
    logic           stall;
    logic           can_issue;
    logic           issue;
    logic           rnd_empty;

    fullxor_rnd_fifo #(
        .K_WIDTH (K_WIDTH),
        .RANDNUM (RANDNUM),
        .RSETS   (RSETS)
    ) u_rnd_fifo (
        .clk        (clk),
        .rst        (rst),
        .word_vld_i (rng_vld),
        .word_dat_i (rng_data),
        .word_rdy_o (rng_rdy),
        .pop_i      (issue),
        .set_dat_o  (fx_rnd),
        .empty_o    (rnd_empty)
    );

    assign stall     = fx_ovld & ~rsp_rdy;
    // FullXOR must clock through its own reset even if a stale result is pending.
    assign fx_ena    = rst | ~stall;
    assign can_issue = ~rnd_empty & (|req_vld) & ~stall;

    // First requester strictly after the last grant, wrapping.
    always_comb begin
        grant_idx   = rr_q;
        grant_found = 1'b0;
        arb_idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            arb_idx = int'(rr_q) + i;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!grant_found && req_vld[arb_idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(arb_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (can_issue) state_d = ISSUE;
            end
            ISSUE, STALL: begin
                if (stall)          state_d = STALL;
                else if (can_issue) state_d = ISSUE;
                else                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Conditions are re-qualified in ISSUE since requesters or the set supply may have changed.
    always_comb begin
        issue   = (state_q == ISSUE) & can_issue & grant_found & ~rst;
        req_rdy = issue ? (NREQ'(1) << grant_idx) : '0;
        fx_dvld = issue;
    end

    assign fx_x = req_x[int'(grant_idx)*K_WIDTH*N_SHARES +: K_WIDTH*N_SHARES];

    always_comb begin
        rr_d     = issue ? grant_idx : rr_q;
        op_cnt_d = issue ? op_cnt_q + 16'd1 : op_cnt_q;
        rsp_id_d = (fx_dvld & fx_ena) ? grant_idx : rsp_id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= IDW'(NREQ - 1);
            op_cnt_q <= '0;
            rsp_id_q <= '0;
        end else begin
            rr_q     <= rr_d;
            op_cnt_q <= op_cnt_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign fx_rst_n = ~rst;
    assign rsp_vld  = fx_ovld;
    assign rsp_z    = fx_z;
    assign rsp_id   = rsp_id_q;
    assign op_cnt   = op_cnt_q;
    assign busy     = fx_ovld | (|req_vld);

endmodule

// File: tb/tb_fullxor_sched.sv
// Bench for fullxor_sched with a behavioural 3-share FullXOR and a response/randomness scoreboard.
module tb_fullxor_sched;

    localparam int K    = 32;
    localparam int NS   = 3;
    localparam int RN   = 2;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ*K*NS-1:0] req_x;
    logic [NREQ-1:0]      req_rdy;
    logic                 rng_vld;
    logic [K-1:0]         rng_data;
    logic                 rng_rdy;
    logic                 rsp_vld;
    logic [K-1:0]         rsp_z;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_rdy;
    logic                 fx_rst_n;
    logic                 fx_dvld;
    logic                 fx_ena;
    logic [K*RN-1:0]      fx_rnd;
    logic [K*NS-1:0]      fx_x;
    logic [K-1:0]         fx_z;
    logic                 fx_ovld;
    logic                 busy;
    logic [15:0]          op_cnt;

    always #5 clk = ~clk;

    fullxor_sched #(
        .K_WIDTH (K),
        .N_SHARES(NS),
        .NREQ    (NREQ),
        .RSETS   (2)
    ) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .rng_vld(rng_vld), .rng_data(rng_data), .rng_rdy(rng_rdy),
        .rsp_vld(rsp_vld), .rsp_z(rsp_z), .rsp_id(rsp_id), .rsp_rdy(rsp_rdy),
        .fx_rst_n(fx_rst_n), .fx_dvld(fx_dvld), .fx_ena(fx_ena), .fx_rnd(fx_rnd),
        .fx_x(fx_x), .fx_z(fx_z), .fx_ovld(fx_ovld), .busy(busy), .op_cnt(op_cnt)
    );

    // Behavioural FullXOR: one register stage, result is the XOR of the three shares.
    always @(posedge clk) begin
        if (!fx_rst_n) begin
            fx_ovld <= 1'b0;
            fx_z    <= '0;
        end else if (fx_ena) begin
            fx_ovld <= fx_dvld;
            if (fx_dvld) fx_z <= fx_x[0 +: K] ^ fx_x[K +: K] ^ fx_x[2*K +: K];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [K-1:0]   z;
    } exp_t;

    exp_t            expq[$];
    logic [K-1:0]    rndw[$];
    int              exp_rr = NREQ - 1;
    logic            prev_dvld = 1'b0;
    int              mon_g;
    int              mon_idx;
    exp_t            mon_e;
    logic [NREQ-1:0] mon_oh;
    logic [K*NS-1:0] mon_x;
    logic [K-1:0]    last_z;
    logic [IDW-1:0]  last_id;
    logic [K*RN-1:0] last_grant_rnd;
    int              glog[16];
    int              gcnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            rndw.delete();
            exp_rr    = NREQ - 1;
            prev_dvld = 1'b0;
            gcnt      = 0;
        end else begin
            if (prev_dvld) check_eq("latency", rsp_vld, 1);
            if (rsp_vld && rsp_rdy) begin
                if (expq.size() == 0) begin
                    check_eq("rsp_unexpected", rsp_vld, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check_eq("rsp_z", rsp_z, mon_e.z);
                    check_eq("rsp_id", rsp_id, mon_e.id);
                    last_z  = rsp_z;
                    last_id = rsp_id;
                end
            end
            if (fx_dvld) begin
                mon_g = -1;
                for (int i = 1; i <= NREQ; i++) begin
                    mon_idx = (exp_rr + i) % NREQ;
                    if (mon_g < 0 && req_vld[mon_idx]) mon_g = mon_idx;
                end
                mon_oh = '0;
                if (mon_g >= 0) mon_oh[mon_g] = 1'b1;
                check_eq("grant", req_rdy, mon_oh);
                if (mon_g >= 0) begin
                    exp_rr = mon_g;
                    mon_x  = req_x[mon_g*K*NS +: K*NS];
                    check_eq("fx_x", fx_x, mon_x);
                    mon_e.id = IDW'(mon_g);
                    mon_e.z  = mon_x[0 +: K] ^ mon_x[K +: K] ^ mon_x[2*K +: K];
                    expq.push_back(mon_e);
                    if (gcnt < 16) glog[gcnt] = mon_g;
                    gcnt++;
                end
                if (rndw.size() < 2) begin
                    check_eq("rnd_avail", rndw.size(), 2);
                end else begin
                    check_eq("fx_rnd", fx_rnd, {rndw[1], rndw[0]});
                    void'(rndw.pop_front());
                    void'(rndw.pop_front());
                end
                last_grant_rnd = fx_rnd;
            end else begin
                check_eq("no_grant", req_rdy, 0);
            end
            if (rng_vld && rng_rdy) rndw.push_back(rng_data);
            prev_dvld = fx_dvld;
        end
    end

    logic [NREQ-1:0] pend = '0, add = '0, sticky = '0, g_seen = '0;
    logic            rng_auto = 1'b0, bp = 1'b0, rst_v = 1'b1;
    logic [K-1:0]    wq[$];

    // All DUT inputs change 1 time unit after the rising edge; returns 1 unit after the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        rst     = rst_v;
        rsp_rdy = ~bp;
        for (int i = 0; i < NREQ; i++)
            if (g_seen[i]) req_x[i*K*NS +: K*NS] = {$urandom, $urandom, $urandom};
        pend    = (pend & ~g_seen) | add;
        add     = '0;
        req_vld = pend | sticky;
        if (wq.size() > 0) begin
            rng_vld  = 1'b1;
            rng_data = wq.pop_front();
        end else if (rng_auto) begin
            rng_vld  = 1'b1;
            rng_data = $urandom;
        end else begin
            rng_vld = 1'b0;
        end
        @(negedge clk);
        g_seen = req_vld & req_rdy;
        #1;
    endtask

    task automatic reset_dut(input int n);
        rst_v = 1'b1; pend = '0; add = '0; sticky = '0; bp = 1'b0; rng_auto = 1'b0;
        repeat (n) step();
        rst_v = 1'b0;
        step();
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        step();
        while (g_seen == '0 && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, g_seen != '0, 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((pend != '0 || add != '0 || expq.size() != 0 || rsp_vld) && n < 300) begin
            step();
            n++;
        end
        check_eq(tag, n < 300, 1);
    endtask

    task automatic starve(input logic [K-1:0] w0, input logic [K-1:0] w1);
        wq.push_back(w0);
        add = 4'b0001;
        step();
        repeat (4) begin
            step();
            check_eq("starve_nogrant", req_rdy, 0);
            check_eq("starve_busy", busy, 1);
        end
        wq.push_back(w1);
        wait_grant("starve_grant");
        check_eq("starve_rnd", last_grant_rnd, {w1, w0});
        drain("starve_drain");
    endtask

    logic [K-1:0]   cap_z;
    logic [IDW-1:0] cap_id;
    logic [15:0]    cap_cnt;

    initial begin
        rst = 1'b1; req_vld = '0; req_x = '0; rng_vld = 1'b0; rng_data = '0; rsp_rdy = 1'b1;

        // Reset with every requester asserting.
        sticky = '1;
        repeat (3) begin
            step();
            check_eq("rst_req_rdy", req_rdy, 0);
            check_eq("rst_rsp_vld", rsp_vld, 0);
            check_eq("rst_op_cnt", op_cnt, 0);
            check_eq("rst_rng_rdy", rng_rdy, 0);
        end
        sticky = '0;
        rst_v  = 1'b0;
        step();
        check_eq("post_rst_rng_rdy", rng_rdy, 1);
        check_eq("post_rst_rsp_id", rsp_id, 0);
        check_eq("post_rst_busy", busy, 0);

        // Single operation from requester 1.
        wq.push_back(32'hA5A5A5A5);
        wq.push_back(32'h0F0F0F0F);
        step();
        step();
        req_x[1*K*NS +: K*NS] = {32'h44, 32'h22, 32'h11};
        add = 4'b0010;
        wait_grant("single_grant");
        check_eq("single_rnd", last_grant_rnd, {32'h0F0F0F0F, 32'hA5A5A5A5});
        step();
        check_eq("single_rsp_vld", rsp_vld, 1);
        check_eq("single_rsp_z", rsp_z, 32'h77);
        check_eq("single_rsp_id", rsp_id, 1);
        drain("single_drain");
        check_eq("single_op_cnt", op_cnt, 1);

        // Fairness from a fresh round-robin pointer.
        reset_dut(2);
        rng_auto = 1'b1;
        add      = 4'hF;
        drain("fair_drain");
        rng_auto = 1'b0;
        check_eq("fair_gcnt", gcnt, 4);
        for (int i = 0; i < 4; i++) check_eq("fair_order", glog[i], i);
        check_eq("fair_op_cnt", op_cnt, 4);

        // Randomness starvation.
        reset_dut(2);
        starve(32'hDEADBEEF, 32'h12345678);

        // Back-pressure during a continuous stream.
        rng_auto = 1'b1;
        sticky   = 4'hF;
        begin
            int n = 0;
            step();
            while (!rsp_vld && n < 40) begin step(); n++; end
            check_eq("bp_stream", rsp_vld, 1);
            bp = 1'b1;
            n  = 0;
            step();
            while (!rsp_vld && n < 40) begin step(); n++; end
            check_eq("bp_held", rsp_vld, 1);
        end
        cap_z   = rsp_z;
        cap_id  = rsp_id;
        cap_cnt = op_cnt;
        repeat (3) begin
            step();
            check_eq("bp_fx_ena", fx_ena, 0);
            check_eq("bp_req_rdy", req_rdy, 0);
            check_eq("bp_rsp_vld", rsp_vld, 1);
            check_eq("bp_rsp_z", rsp_z, cap_z);
            check_eq("bp_rsp_id", rsp_id, cap_id);
            check_eq("bp_op_cnt", op_cnt, cap_cnt);
        end
        bp     = 1'b0;
        sticky = '0;
        drain("bp_drain");
        rng_auto = 1'b0;

        // Reset in an issue cycle with the buffer holding both sets.
        reset_dut(1);
        repeat (4) wq.push_back($urandom);
        repeat (5) step();
        check_eq("mid_buf_full", rng_rdy, 0);
        sticky = 4'b0001;
        wait_grant("mid_first_grant");
        rst_v  = 1'b1;
        sticky = '0;
        step();
        check_eq("mid_rst_nogrant", req_rdy, 0);
        rst_v = 1'b0;
        repeat (4) begin
            step();
            check_eq("mid_no_rsp", rsp_vld, 0);
        end
        starve(32'hCAFEF00D, 32'h5A5A1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
